// File: rtl/sin_wave_gen_pkg.sv
// sin_gen_pkg: shared widths and quadrant encoding for the sine generator family.
package sin_gen_pkg;
    localparam int PHASE_W  = 12;
    localparam int FREQ_W   = 7;
    localparam int ROM_AW   = 5;
    localparam int AMPL_W   = 6;
    localparam int SAMPLE_W = 7;
    typedef enum logic [1:0] {Q0_RISE, Q1_FALL, Q2_NEG_FALL, Q3_NEG_RISE} quadrant_e;
endpackage

// File: rtl/sin_wave_gen_if.sv
// sin_wave_gen_if: link between the generator and its external quarter-wave ROM.
interface sin_wave_gen_if;
    import sin_gen_pkg::*;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_en;
    logic [AMPL_W-1:0] rom_data;
    modport master (output rom_addr, output rom_en, input rom_data);
    modport slave  (input rom_addr, input rom_en, output rom_data);
endinterface

// File: rtl/sin_wave_gen_quadrant_map.sv
// sin_quadrant_map: folds a full-wave {quadrant, index} onto the quarter-wave ROM address and sign.
module sin_quadrant_map import sin_gen_pkg::*; (
    input  quadrant_e         quad_i,
    input  logic [ROM_AW-1:0] index_i,
    output logic [ROM_AW-1:0] addr_o,
    output logic              neg_o
);
    assign addr_o = (quad_i == Q1_FALL || quad_i == Q3_NEG_RISE) ? ~index_i : index_i;
    assign neg_o  = (quad_i == Q2_NEG_FALL || quad_i == Q3_NEG_RISE);
endmodule

// File: rtl/sin_wave_gen.sv
// sin_wave_gen: one signed sine sample per accepted tick, 3-cycle latency through an external
// registered quarter-wave ROM; the sign travels alongside the ROM read to stay aligned.
module sin_wave_gen #(
    parameter int PHASE_W = sin_gen_pkg::PHASE_W,
    parameter int FREQ_W  = sin_gen_pkg::FREQ_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  sync,
    input  logic                                  sample_tick,
    input  logic [FREQ_W-1:0]                     freq_word,
    sin_wave_gen_if.master                        rom,
    output logic [sin_gen_pkg::SAMPLE_W-1:0]      sample_out,
    output logic                                  sample_valid
);
    import sin_gen_pkg::*;
    logic [PHASE_W-1:0]  phase_q, phase_d, p_use;
    logic [ROM_AW-1:0]   addr_q, addr_d, map_addr;
    logic [SAMPLE_W-1:0] sample_q, sample_d, mag;
    logic                map_neg, accept, rom_en_q;
    logic                neg_s1_q, neg_s1_d, vld_s1_q, neg_s2_q, vld_s2_q, valid_q, valid_d;
    quadrant_e           quad;

    assign p_use  = sync ? '0 : phase_q;
    assign quad   = quadrant_e'(p_use[PHASE_W-1 -: 2]);
    assign accept = en & sample_tick;
    assign mag    = {1'b0, rom.rom_data};

    sin_quadrant_map u_map (
        .quad_i  (quad),
        .index_i (p_use[PHASE_W-3 -: ROM_AW]),
        .addr_o  (map_addr),
        .neg_o   (map_neg)
    );

    // Without a tick, p_use already carries a lone sync's phase clear.
    always_comb begin
        phase_d  = !en ? '0 : accept ? p_use + PHASE_W'(freq_word) : p_use;
        addr_d   = accept ? map_addr : addr_q;
        neg_s1_d = accept ? map_neg : neg_s1_q;
        sample_d = !en ? '0 : vld_s2_q ? (neg_s2_q ? -mag : mag) : sample_q;
        valid_d  = en & vld_s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= '0;
            addr_q   <= '0;
            rom_en_q <= 1'b0;
            neg_s1_q <= 1'b0;
            vld_s1_q <= 1'b0;
            neg_s2_q <= 1'b0;
            vld_s2_q <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            addr_q   <= addr_d;
            rom_en_q <= en;
            neg_s1_q <= neg_s1_d;
            vld_s1_q <= accept;
            neg_s2_q <= neg_s1_q;
            vld_s2_q <= en & vld_s1_q;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign rom.rom_addr = addr_q;
    assign rom.rom_en   = rom_en_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
endmodule

// File: tb/tb_sin_wave_gen.sv
// tb_sin_wave_gen: directed stimulus with a queue scoreboard; the quarter-wave ROM lives here.
module tb_sin_wave_gen;
    logic        clk = 1'b0;
    logic        rst, en, sync, sample_tick;
    logic [6:0]  freq_word;
    logic [6:0]  sample_out;
    logic        sample_valid;
    int          checks = 0, errors = 0;
    int          exp_q[$], got_q[$];
    logic [11:0] ph_m = '0;
    logic [5:0]  rom_tab [32] = '{0, 2, 3, 5, 6, 8, 9, 10, 12, 13, 15, 16, 17, 18, 20, 21,
                                  22, 23, 24, 25, 26, 27, 27, 28, 29, 29, 30, 30, 30, 31, 31, 31};
    int          ks [10] = '{0, 1, 31, 32, 63, 64, 65, 95, 96, 127};
    int          vs [10] = '{0, 2, 31, 31, 0, 0, -2, -31, -31, 0};
    int          base;

    sin_wave_gen_if rom_if ();

    sin_wave_gen #(.PHASE_W(12), .FREQ_W(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sync         (sync),
        .sample_tick  (sample_tick),
        .freq_word    (freq_word),
        .rom          (rom_if),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_if.rom_en) rom_if.rom_data <= rom_tab[rom_if.rom_addr];

    function automatic int model(input logic [11:0] p);
        logic [4:0] a;
        a = p[10] ? ~p[9:5] : p[9:5];
        return p[11] ? -int'(rom_tab[a]) : int'(rom_tab[a]);
    endfunction

    function automatic int got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : -99;
    endfunction

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic step(input logic t, input logic s);
        logic [11:0] p;
        sample_tick = t;
        sync = s;
        if (rst || !en) ph_m = '0;
        else if (t) begin
            p = s ? 12'd0 : ph_m;
            exp_q.push_back(model(p));
            ph_m = p + 12'(freq_word);
        end else if (s) ph_m = '0;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 1'b0);
        chk("drain_pending", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (sample_valid) begin
            int got;
            got = int'($signed(sample_out));
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got sample %0d, required no sample_valid", got);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (got != e) begin
                    errors++;
                    $display("FAIL sample: got %0d, required %0d", got, e);
                end
            end
            checks++;
            if (got > 31 || got < -31) begin
                errors++;
                $display("FAIL range: got %0d, required -31..31", got);
            end
            got_q.push_back(got);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; sync = 1'b0; sample_tick = 1'b0; freq_word = 7'd32;
        @(negedge clk);
        repeat (3) step(1'b1, 1'b0);
        chk("rst_sample_out", sample_out, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_rom_addr", rom_if.rom_addr, 0);
        chk("rst_rom_en", rom_if.rom_en, 0);
        rst = 1'b0;
        repeat (3) begin
            step(1'b0, 1'b0);
            chk("post_rst_no_valid", sample_valid, 0);
        end

        base = got_q.size();
        for (int k = 0; k < 128; k++) step(1'b1, 1'b0);
        drain();
        for (int i = 0; i < 10; i++) chk($sformatf("seq32_k%0d", ks[i]), got_at(base + ks[i]), vs[i]);

        step(1'b1, 1'b0);
        drain();
        step(1'b1, 1'b0);
        chk("lat_rom_addr_c1", rom_if.rom_addr, 1);
        chk("lat_valid_c1", sample_valid, 0);
        step(1'b0, 1'b0);
        chk("lat_valid_c2", sample_valid, 0);
        step(1'b0, 1'b0);
        chk("lat_valid_c3", sample_valid, 1);
        chk("lat_sample_c3", int'($signed(sample_out)), 2);
        step(1'b0, 1'b0);
        chk("lat_valid_c4", sample_valid, 0);

        step(1'b0, 1'b1);
        base = got_q.size();
        for (int k = 0; k < 56; k++) step(1'b1, k == 50);
        drain();
        chk("lone_sync_first", got_at(base), 0);
        chk("sync_tick_k50", got_at(base + 50), 0);
        chk("sync_tick_k51", got_at(base + 51), 2);

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        chk("rom_en_before_drop", rom_if.rom_en, 1);
        en = 1'b0;
        step(1'b0, 1'b0);
        chk("drop_rom_en", rom_if.rom_en, 0);
        chk("drop_sample_out", sample_out, 0);
        chk("drop_valid", sample_valid, 0);
        repeat (4) begin
            step(1'b0, 1'b0);
            chk("drop_no_valid", sample_valid, 0);
        end
        en = 1'b1;
        base = got_q.size();
        step(1'b1, 1'b0);
        drain();
        chk("reenable_first", got_at(base), 0);

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        repeat (4) begin
            step(1'b0, 1'b0);
            chk("midrst_no_valid", sample_valid, 0);
        end

        freq_word = 7'd127;
        for (int k = 0; k < 200; k++) step(1'b1, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sin_wave_gen.md
# sin_wave_gen

Full-period sine sample generator. It drives the 32-entry quarter-wave amplitude ROM, whose output is 6-bit, registered, with one cycle of read latency. It reconstructs the full signed waveform from that ROM by address mirroring and sign application. It sits between the note/frequency control logic and the synth mixer, producing one signed sample per `sample_tick`.

## Interface
Parameters:
- `PHASE_W`, 12: phase accumulator width. The top 7 bits are {quadrant[1:0], index[4:0]}.
- `FREQ_W`, 7: phase increment width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: generator enable.
- `sync` in 1: hard-sync pulse; forces the phase to 0.
- `sample_tick` in 1: one-cycle strobe requesting the next sample.
- `freq_word` in FREQ_W: unsigned phase increment, added once per tick.
- `rom_addr` out 5: quarter-wave ROM address, registered.
- `rom_en` out 1: ROM enable, registered copy of `en`.
- `rom_data` in 6: ROM amplitude (0..31), valid the cycle after `rom_addr`/`rom_en`.
- `sample_out` out 7: two's-complement sample, range -31..+31.
- `sample_valid` out 1: one-cycle strobe marking a new `sample_out`.

## Operation
- Reset (`rst`=1): phase, `rom_addr`, `rom_en`, `sample_out`, `sample_valid` and all pipeline flags clear to 0.
- Phase select: `p_use` = `sync` ? 0 : `phase`.
- On `sample_tick` with `en`=1:
  - `rom_addr` <= map(`p_use`)
  - `phase` <= `p_use` + `freq_word`, mod 2^PHASE_W, wrapping silently.
  - `neg_s1` <= quadrant[1]
  - `vld_s1` <= 1
- `sync` without a tick: `phase` <= 0; the pipeline is unaffected.
- `sync` and tick together: sync wins. The sample uses phase 0 and the accumulator becomes `freq_word`.
- Address map:
  - quadrant 0: addr = index, positive.
  - quadrant 1: addr = ~index (31 - index), positive.
  - quadrant 2: addr = index, negative.
  - quadrant 3: addr = ~index, negative.
- Pipeline stage 2: `neg_s2` <= `neg_s1`, `vld_s2` <= `vld_s1`. This aligns the sign with the ROM output.
- Output stage: when `vld_s2` is set, `sample_out` <= `neg_s2` ? -{0,`rom_data`} : {0,`rom_data`}, and `sample_valid` <= 1. Otherwise `sample_valid` <= 0 and `sample_out` holds.
- `en`=0:
  - ticks are ignored; `phase` <= 0; `vld_s1` and `vld_s2` clear.
  - `rom_en` drops the next cycle.
  - `sample_out` <= 0 once the pipeline drains. Samples already in flight are discarded, not emitted.
- Re-enable: the first tick emits sin(0) = 0.
- Ticks between tick-to-output completions are legal, including a tick every cycle. The pipeline is fully throughput-1.
- `freq_word`=0: the generator holds the same sample on every tick.

## Timing
- Tick in cycle 0 → `rom_addr` valid in cycle 1 → `rom_data` valid in cycle 2 → `sample_out`/`sample_valid` in cycle 3.
- Fixed latency is 3 cycles; `sample_valid` is high for exactly 1 cycle per accepted tick.
- `rom_en` follows `en` with 1-cycle delay. A tick in the first cycle `en` is high is accepted; the ROM sees `rom_en`=1 when it captures the address.
- `rst` mid-operation clears everything on the next edge. No `sample_valid` is produced for ticks in flight.
- `freq_word` and `sync` are sampled only in the tick cycle, except that `sync` alone also acts without a tick.

## Structure
- Package `sin_gen_pkg`:
  - `PHASE_W`, `FREQ_W`, `ROM_AW`=5, `AMPL_W`=6, `SAMPLE_W`=7.
  - quadrant enum: Q0_RISE, Q1_FALL, Q2_NEG_FALL, Q3_NEG_RISE.
- Sub-module `sin_quadrant_map`: combinational; maps {quadrant, index} to {addr, neg}. It is reused by the future cosine/LFO generator.
- The ROM is instantiated at the top level alongside this block, not inside it.

## Test plan
- Reset with `en`=1 and ticks active → all outputs 0, no `sample_valid` while `rst`=1 and for 3 cycles after.
- `freq_word`=32, tick every cycle, 128 ticks → samples k=0,1,31,32,63,64,65,95,96,127 = 0, 2, 31, 31, 0, 0, -2, -31, -31, 0. The sequence then repeats with period 128.
- Latency: single tick in cycle 0 → `rom_addr` changes in cycle 1, `sample_valid` exactly in cycle 3.
- `sync` together with a tick at k=50 (`freq_word`=32) → that sample = 0, the next = 2. A lone `sync` with no tick → the next tick yields 0.
- `en` dropped with 2 samples in flight → no `sample_valid`, `rom_en`=0 next cycle, `sample_out`=0. Re-enable plus tick → first sample 0.
- `freq_word`=127 wrap test, 200 ticks → phase wraps mod 4096. Every sample matches a reference model and stays within -31..31.
